// File: rtl/tx_arbiter_pkg.sv
// Shared TX channel definitions: command headers, start pattern, arbiter state
// encoding and payload length per command.
package tx_arbiter_pkg;

    localparam int unsigned NSHIFT         = 2;
    localparam int unsigned PAYLOAD_CYCLES = 8;
    localparam int unsigned TX_CMD_BITS    = 2;
    localparam int unsigned TX_CNT_BITS    = $clog2(PAYLOAD_CYCLES) + 1;

    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16 = 2'b01;
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 2'b10;
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_8 = 2'b11;
    localparam logic [NSHIFT-1:0]      TX_START_PATTERN = '1;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StStart   = 2'b01,
        StCmd     = 2'b10,
        StPayload = 2'b11
    } tx_arb_state_e;

    function automatic logic [TX_CNT_BITS-1:0] payload_len(input logic [TX_CMD_BITS-1:0] cmd);
        if (cmd == TX_HEADER_WRITE_8) begin
            return TX_CNT_BITS'(PAYLOAD_CYCLES / 2);
        end
        return TX_CNT_BITS'(PAYLOAD_CYCLES);
    endfunction

endpackage

// File: rtl/tx_arb_grant.sv
// Grant logic for the TX channel. Fixed scheduler priority by default;
// TX_ARB_RR_EN adds an rr_last flop that hands the next tie to the prefetcher.
module tx_arb_grant (
`ifdef TX_ARB_RR_EN
    input  logic clk,
    input  logic reset_n,
`endif
    input  logic idle,
    input  logic sched_valid,
    input  logic pf_valid,
    input  logic sched_reserve,
    output logic grant_sched,
    output logic grant_pf
);

`ifdef TX_ARB_RR_EN
    logic rr_last_q;

    // Reserve always blocks the prefetcher, even when it holds the round-robin turn.
    always_comb begin
        grant_pf    = idle && pf_valid && !sched_reserve && (!sched_valid || rr_last_q);
        grant_sched = idle && sched_valid && !grant_pf;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q <= 1'b0;
        end else if (grant_sched || grant_pf) begin
            rr_last_q <= grant_sched;
        end
    end
`else
    always_comb begin
        grant_sched = idle && sched_valid;
        grant_pf    = idle && pf_valid && !sched_reserve && !sched_valid;
    end
`endif

endmodule

// File: rtl/tx_arbiter.sv
// Shares the serial TX pins between scheduler and PC prefetcher, sequencing
// START, CMD and PAYLOAD cycles per frame. Optional round-robin: TX_ARB_RR_EN.
module tx_arbiter
    import tx_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sched_cmd_valid,
    input  logic [TX_CMD_BITS-1:0] sched_cmd,
    input  logic                   sched_reserve,
    input  logic [NSHIFT-1:0]      sched_data,
    output logic                   sched_started,
    input  logic                   pf_req_valid,
    input  logic [NSHIFT-1:0]      pf_data,
    output logic                   pf_started,
    output logic                   owner_is_sched,
    output logic                   tx_active,
    output logic                   tx_data_next,
    output logic [TX_CNT_BITS-1:0] tx_counter,
    output logic                   tx_done,
    output logic [NSHIFT-1:0]      tx_pins
);

    tx_arb_state_e          state_q;
    logic [TX_CMD_BITS-1:0] cmd_q;
    logic                   owner_q;
    logic [TX_CNT_BITS-1:0] cnt_q;
    logic                   grant_sched;
    logic                   grant_pf;
    logic                   last_beat;

    tx_arb_grant u_grant (
`ifdef TX_ARB_RR_EN
        .clk           (clk),
        .reset_n       (reset_n),
`endif
        .idle          (state_q == StIdle),
        .sched_valid   (sched_cmd_valid),
        .pf_valid      (pf_req_valid),
        .sched_reserve (sched_reserve),
        .grant_sched   (grant_sched),
        .grant_pf      (grant_pf)
    );

    assign last_beat = (cnt_q == payload_len(cmd_q) - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_sched || grant_pf) begin
                        owner_q <= grant_sched;
                        cmd_q   <= grant_sched ? sched_cmd : TX_HEADER_READ_16;
                        state_q <= StStart;
                    end
                end
                StStart: state_q <= StCmd;
                StCmd: begin
                    cnt_q   <= '0;
                    state_q <= StPayload;
                end
                StPayload: begin
                    // Counter stops on the last beat so it holds N-1 while idle.
                    if (last_beat) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        sched_started  = grant_sched;
        pf_started     = grant_pf;
        owner_is_sched = owner_q;
        tx_counter     = cnt_q;
        tx_active      = (state_q != StIdle);
        tx_data_next   = (state_q == StPayload);
        tx_done        = (state_q == StPayload) && last_beat;
        tx_pins        = '0;
        unique case (state_q)
            StIdle:    tx_pins = '0;
            StStart:   tx_pins = TX_START_PATTERN;
            StCmd:     tx_pins = cmd_q;
            StPayload: tx_pins = owner_q ? sched_data : pf_data;
            default:   tx_pins = '0;
        endcase
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter; the priority test adapts its
// expectation to TX_ARB_RR_EN.
module tb_tx_arbiter;
    import tx_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sched_cmd_valid = 1'b0;
    logic [1:0] sched_cmd = 2'b00;
    logic       sched_reserve = 1'b0;
    logic [1:0] sched_data = 2'b00;
    logic       sched_started;
    logic       pf_req_valid = 1'b0;
    logic [1:0] pf_data = 2'b00;
    logic       pf_started;
    logic       owner_is_sched;
    logic       tx_active;
    logic       tx_data_next;
    logic [3:0] tx_counter;
    logic       tx_done;
    logic [1:0] tx_pins;

    int total = 0;
    int bad = 0;

    tx_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sched_cmd_valid (sched_cmd_valid),
        .sched_cmd       (sched_cmd),
        .sched_reserve   (sched_reserve),
        .sched_data      (sched_data),
        .sched_started   (sched_started),
        .pf_req_valid    (pf_req_valid),
        .pf_data         (pf_data),
        .pf_started      (pf_started),
        .owner_is_sched  (owner_is_sched),
        .tx_active       (tx_active),
        .tx_data_next    (tx_data_next),
        .tx_counter      (tx_counter),
        .tx_done         (tx_done),
        .tx_pins         (tx_pins)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        sched_cmd_valid = 1'b0;
        pf_req_valid = 1'b0;
        sched_reserve = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (tx_pins !== 2'b00) begin bad++; $display("FAIL reset_pins got=%b exp=00", tx_pins); end
        total++;
        if ({tx_active, tx_done, tx_data_next, sched_started, pf_started, owner_is_sched} !== 6'b0)
        begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {tx_active, tx_done, tx_data_next, sched_started, pf_started, owner_is_sched});
        end
        total++;
        if (tx_counter !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", tx_counter); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_write16();
        @(posedge clk); #1;
        sched_cmd = TX_HEADER_WRITE_16;
        sched_data = 2'b10;
        sched_cmd_valid = 1'b1;
        @(negedge clk);
        total++;
        if (sched_started !== 1'b1 || pf_started !== 1'b0 || tx_active !== 1'b0) begin
            bad++;
            $display("FAIL w16_grant got=%b%b%b exp=100", sched_started, pf_started, tx_active);
        end
        @(posedge clk); #1;
        sched_cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (tx_pins !== 2'b11 || tx_active !== 1'b1 || sched_started !== 1'b0) begin
            bad++;
            $display("FAIL w16_start got=%b/%b/%b exp=11/1/0", tx_pins, tx_active, sched_started);
        end
        @(negedge clk);
        total++;
        if (tx_pins !== 2'b10) begin bad++; $display("FAIL w16_cmd got=%b exp=10", tx_pins); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (tx_pins !== 2'b10 || tx_counter !== 4'(k) || tx_done !== (k == 7) ||
                tx_data_next !== 1'b1) begin
                bad++;
                $display("FAIL w16_payload%0d got=pins %b cnt %0d done %b dn %b exp=10 %0d %b 1",
                         k, tx_pins, tx_counter, tx_done, tx_data_next, k, (k == 7));
            end
        end
        @(negedge clk);
        total++;
        if (tx_active !== 1'b0 || tx_pins !== 2'b00 || tx_done !== 1'b0) begin
            bad++;
            $display("FAIL w16_idle got=%b/%b/%b exp=0/00/0", tx_active, tx_pins, tx_done);
        end
    endtask

    task automatic test_write8();
        @(posedge clk); #1;
        sched_cmd = TX_HEADER_WRITE_8;
        sched_data = 2'b01;
        sched_cmd_valid = 1'b1;
        @(negedge clk);
        total++;
        if (sched_started !== 1'b1) begin bad++; $display("FAIL w8_grant got=%b exp=1", sched_started); end
        @(posedge clk); #1;
        sched_cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (tx_pins !== 2'b11) begin bad++; $display("FAIL w8_cmd got=%b exp=11", tx_pins); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (tx_pins !== 2'b01 || tx_counter !== 4'(k) || tx_done !== (k == 3)) begin
                bad++;
                $display("FAIL w8_payload%0d got=pins %b cnt %0d done %b exp=01 %0d %b",
                         k, tx_pins, tx_counter, tx_done, k, (k == 3));
            end
        end
        @(negedge clk);
        total++;
        if (tx_active !== 1'b0 || tx_counter !== 4'd3) begin
            bad++;
            $display("FAIL w8_idle got=act %b cnt %0d exp=0 3", tx_active, tx_counter);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(posedge clk); #1;
        sched_cmd = TX_HEADER_WRITE_16;
        sched_data = 2'b10;
        pf_data = 2'b11;
        sched_cmd_valid = 1'b1;
        pf_req_valid = 1'b1;
        @(negedge clk);
        total++;
        if (sched_started !== 1'b1 || pf_started !== 1'b0) begin
            bad++;
            $display("FAIL sim_grant got=%b%b exp=10", sched_started, pf_started);
        end
        @(posedge clk); #1;
        sched_cmd_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (pf_started !== 1'b0 || owner_is_sched !== 1'b1) begin
                bad++;
                $display("FAIL sim_wait%0d got=pf %b own %b exp=0 1", c, pf_started, owner_is_sched);
            end
        end
        @(negedge clk);
        total++;
        if (pf_started !== 1'b1 || tx_active !== 1'b0) begin
            bad++;
            $display("FAIL sim_pf_grant got=%b/%b exp=1/0", pf_started, tx_active);
        end
        @(posedge clk); #1;
        pf_req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (tx_pins !== 2'b11 || owner_is_sched !== 1'b0) begin
            bad++;
            $display("FAIL sim_pf_start got=%b/%b exp=11/0", tx_pins, owner_is_sched);
        end
        @(negedge clk);
        total++;
        if (tx_pins !== 2'b01) begin bad++; $display("FAIL sim_pf_cmd got=%b exp=01", tx_pins); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (tx_pins !== 2'b11 || tx_done !== (k == 7)) begin
                bad++;
                $display("FAIL sim_pf_payload%0d got=%b/%b exp=11/%b", k, tx_pins, tx_done, (k == 7));
            end
        end
    endtask

    task automatic test_reserve();
        @(posedge clk); #1;
        pf_data = 2'b01;
        pf_req_valid = 1'b1;
        sched_reserve = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (pf_started !== 1'b0 || tx_active !== 1'b0) begin
                bad++;
                $display("FAIL rsv_block%0d got=%b/%b exp=0/0", c, pf_started, tx_active);
            end
        end
        @(posedge clk); #1;
        sched_reserve = 1'b0;
        #1;
        total++;
        if (pf_started !== 1'b1) begin bad++; $display("FAIL rsv_release got=%b exp=1", pf_started); end
        @(posedge clk); #1;
        pf_req_valid = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (tx_done !== 1'b1) begin bad++; $display("FAIL rsv_done got=%b exp=1", tx_done); end
        @(negedge clk);
        total++;
        if (tx_active !== 1'b0) begin bad++; $display("FAIL rsv_idle got=%b exp=0", tx_active); end
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk); #1;
        sched_cmd = TX_HEADER_WRITE_16;
        sched_data = 2'b10;
        sched_cmd_valid = 1'b1;
        @(posedge clk); #1;
        sched_cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (tx_counter !== 4'd3 || tx_pins !== 2'b10) begin
            bad++;
            $display("FAIL mid_pre got=cnt %0d pins %b exp=3 10", tx_counter, tx_pins);
        end
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if (tx_pins !== 2'b00 || tx_active !== 1'b0 || tx_counter !== 4'd0) begin
            bad++;
            $display("FAIL mid_async got=pins %b act %b cnt %0d exp=00 0 0",
                     tx_pins, tx_active, tx_counter);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        sched_cmd = TX_HEADER_WRITE_8;
        sched_data = 2'b01;
        sched_cmd_valid = 1'b1;
        @(negedge clk);
        total++;
        if (sched_started !== 1'b1) begin bad++; $display("FAIL mid_regrant got=%b exp=1", sched_started); end
        @(posedge clk); #1;
        sched_cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (tx_pins !== 2'b11) begin bad++; $display("FAIL mid_restart got=%b exp=11", tx_pins); end
        repeat (6) @(negedge clk);
        total++;
        if (tx_active !== 1'b0) begin bad++; $display("FAIL mid_end got=%b exp=0", tx_active); end
    endtask

    task automatic test_priority();
        logic found;
        logic who;
        logic exp_who;
        do_reset();
        @(posedge clk); #1;
        sched_cmd = TX_HEADER_WRITE_16;
        sched_data = 2'b10;
        pf_data = 2'b01;
        sched_cmd_valid = 1'b1;
        pf_req_valid = 1'b1;
        for (int g = 0; g < 3; g++) begin
            found = 1'b0;
            who = 1'b0;
            for (int n = 0; n < 30 && !found; n++) begin
                @(negedge clk);
                if (sched_started || pf_started) begin
                    found = 1'b1;
                    who = sched_started;
                end
            end
`ifdef TX_ARB_RR_EN
            exp_who = (g != 1);
`else
            exp_who = 1'b1;
`endif
            total++;
            if (!found || who !== exp_who) begin
                bad++;
                $display("FAIL prio_grant%0d got=found %b sched %b exp=1 %b", g, found, who, exp_who);
            end
            @(posedge clk);
        end
        #1;
        sched_cmd_valid = 1'b0;
        pf_req_valid = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write16();
        test_write8();
        test_simultaneous();
        test_reserve();
        test_reset_mid_frame();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
Owns the serial TX pin channel and shares it between two requesters: the instruction scheduler (reads, writes) and the PC prefetcher (read-16 only). It grants one frame at a time and sequences the frame: start cycle, command cycle, then payload cycles. While the frame is sent, it drives tx_active, tx_counter, tx_data_next and tx_done back to the granted requester. It sits between the scheduler/prefetch units and the TX pins.

Parameters:
NSHIFT, 2, bits per cycle on the TX pins and on data paths.
PAYLOAD_CYCLES, 8, payload cycles for 16-bit frames (16/NSHIFT).
TX_CMD_BITS, 2, command width; equals NSHIFT so the command fits in one cycle.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
sched_cmd_valid  in  1  scheduler requests a frame; held stable until sched_started
sched_cmd  in  TX_CMD_BITS  TX_HEADER_READ_16 / WRITE_16 / WRITE_8
sched_reserve  in  1  scheduler will send a frame soon; blocks new prefetch grants
sched_data  in  NSHIFT  scheduler payload data
sched_started  out  1  one-cycle pulse: scheduler frame granted
pf_req_valid  in  1  prefetcher requests a READ_16 frame; held until pf_started
pf_data  in  NSHIFT  prefetch address data
pf_started  out  1  one-cycle pulse: prefetch frame granted
owner_is_sched  out  1  current or last frame belongs to the scheduler
tx_active  out  1  a frame is in progress (START, CMD or PAYLOAD)
tx_data_next  out  1  owner advances its data source this cycle
tx_counter  out  $clog2(PAYLOAD_CYCLES)+1  payload cycle index
tx_done  out  1  pulse on the last payload cycle
tx_pins  out  NSHIFT  serial output

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state IDLE; tx_pins=0, tx_active=0, tx_counter=0, tx_done=0, tx_data_next=0, both started pulses 0, owner_is_sched=0, rr_last=0.
- Reset mid-frame aborts the frame immediately; tx_pins return to 0 asynchronously.
- State machine states: IDLE, START, CMD, PAYLOAD.
- IDLE:
  - tx_pins=0.
  - Grant is evaluated combinationally.
  - If sched_cmd_valid: grant the scheduler.
  - Else if pf_req_valid and !sched_reserve: grant the prefetcher.
  - The started pulse for the winner is combinational in the grant cycle t.
  - At t, the block latches owner and cmd (READ_16 for the prefetcher), and the state goes to START at t+1.
- START: tx_pins = all ones; go to CMD.
- CMD: tx_pins = latched cmd; clear tx_counter; go to PAYLOAD.
- PAYLOAD:
  - tx_pins = owner data, combinational mux, no register.
  - tx_data_next=1.
  - tx_counter increments each cycle.
  - Length N = PAYLOAD_CYCLES, or PAYLOAD_CYCLES/2 for WRITE_8.
  - tx_done=1 when tx_counter==N-1; next state IDLE.
- Timing: the first payload cycle is t+3. A full 16-bit frame occupies cycles t+1..t+10. Every frame is followed by at least one IDLE cycle; there are no back-to-back frames.
- tx_active=1 in START, CMD and PAYLOAD.
- Requests arriving while not IDLE wait. Valid inputs that drop before their grant are ignored; this is a protocol violation and has no defined effect.
- Simultaneous requests: the scheduler wins.
- sched_reserve=1 with only pf_req_valid pending: no grant; the channel stays IDLE.
- tx_counter holds its final value in IDLE until the next CMD.

Optional Feature:
TX_ARB_RR_EN.
- Defined: a 1-bit rr_last flag records the last owner. If rr_last=sched, both requesters are valid and sched_reserve=0, the prefetcher wins. sched_reserve always overrides and forbids prefetch grants.
- Undefined: fixed priority as described in Behaviour; no rr_last register.

Decomposition:
- Shared package / common.vh: TX_CMD_BITS, TX_HEADER_READ_16/WRITE_16/WRITE_8 (existing), new TX_START_PATTERN, the tx_arb state encoding (2 bits) and the payload-length function (N per cmd).
- One sub-module, tx_arb_grant: combinational grant logic plus the rr_last flop under TX_ARB_RR_EN. The FSM and counter stay in tx_arbiter.

Test Plan:
- Scheduler WRITE_16, sched_data=2'b10 constant, valid at t:
  - sched_started@t.
  - tx_pins 11@t+1, cmd@t+2, 10 for t+3..t+10.
  - tx_done@t+10, tx_counter 0..7.
  - IDLE@t+11.
- WRITE_8 → payload 4 cycles; tx_done at tx_counter==3.
- sched_cmd_valid and pf_req_valid both rise at the same cycle → only sched_started. The prefetch grant comes in the first IDLE cycle after tx_done.
- pf_req_valid=1, sched_reserve=1 for 5 cycles → no pf_started, tx_active=0. After reserve drops, pf_started the same cycle.
- reset_n low at tx_counter==3 → tx_pins=0 and tx_active=0 without waiting for a clock edge. After release, IDLE and a new request is granted normally.
- With TX_ARB_RR_EN, both requesters held valid → grants alternate sched, pf, sched. Without it, sched every time.
